// File: rtl/sdiomux_hdx_ctrl.sv
// ---------------------------------------------------------------------------
// sdiomux_hdx_ctrl
//   Fabric-side half-duplex controller for a single SDIOMUX pad cell.
//   Words are shifted out of (TX) or into (RX) the pad LSB first, each one
//   preceded by a '1' start bit. A direction change passes through a TA-cycle
//   turnaround in which both pad enables are high (neither direction on).
//   The pad enables are active-low, matching the cell.
//
// Parameters
//   W   data word width in bits (>= 1)
//   TA  turnaround length in cycles (>= 1)
//
// Ports
//   CLK       in   single clock, rising-edge
//   RST       in   synchronous reset, active-high
//   DIR_REQ   in   requested direction: 1 = transmit, 0 = receive
//   TX_DATA   in   word to transmit, captured only at the handshake
//   TX_VALID  in   TX_DATA valid
//   TX_READY  out  word accepted when TX_VALID & TX_READY at a rising edge
//   RX_DATA   out  last received word, held until the next word completes
//   RX_VALID  out  one-cycle pulse when RX_DATA is updated
//   O_DAT     out  to cell O_DAT (0 whenever O_EN = 1)
//   O_EN      out  to cell O_EN, 0 = output driven
//   I_DAT     in   from cell I_DAT (forced 0 by the cell when I_EN = 1)
//   I_EN      out  to cell I_EN, 0 = input enabled
// ---------------------------------------------------------------------------
module sdiomux_hdx_ctrl #(
  parameter int W  = 8,
  parameter int TA = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         DIR_REQ,
  input  logic [W-1:0] TX_DATA,
  input  logic         TX_VALID,
  output logic         TX_READY,
  output logic [W-1:0] RX_DATA,
  output logic         RX_VALID,
  output logic         O_DAT,
  output logic         O_EN,
  input  logic         I_DAT,
  output logic         I_EN
);

  typedef enum logic [1:0] {
    TURN_RX = 2'd0,
    RX      = 2'd1,
    TURN_TX = 2'd2,
    TX      = 2'd3
  } state_t;

  localparam int TCW = $clog2(TA + 1);
  localparam int BCW = $clog2(W + 1);

  localparam logic [TCW-1:0] TURN_INIT = TCW'(TA);
  localparam logic [TCW-1:0] TURN_ONE  = TCW'(1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [BCW-1:0] RX_LAST   = BCW'(W - 1);
  localparam logic [BCW-1:0] TX_DONE   = BCW'(W);

  state_t         state_q, state_d;
  logic [TCW-1:0] turn_cnt_q, turn_cnt_d;

  logic           rx_busy_q, rx_busy_d;
  logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [W-1:0]   rx_shift_q, rx_shift_d;
  logic [W-1:0]   rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;

  logic           tx_busy_q, tx_busy_d;
  logic [BCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [W-1:0]   tx_shift_q, tx_shift_d;
  logic           tx_ready_q, tx_ready_d;

  logic           o_dat_q, o_dat_d;
  logic           o_en_q, o_en_d;
  logic           i_en_q, i_en_d;

  logic           tx_hs;

  // Next-state logic for the whole controller. Every pad-facing output is
  // computed here one cycle ahead so that it leaves a flop. Within a frame
  // DIR_REQ is simply not looked at; direction only changes from an idle
  // shifter, and the handshake branch is tested before the exit branch so
  // that a handshake beats DIR_REQ=0 on the same edge.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_ready_d = tx_ready_q;
    o_dat_d    = o_dat_q;
    o_en_d     = o_en_q;
    i_en_d     = i_en_q;

    tx_hs = (state_q == TX) && tx_ready_q && TX_VALID;

    case (state_q)
      TURN_RX: begin
        if (turn_cnt_q == TURN_ONE) begin
          state_d = RX;
          i_en_d  = 1'b0;
        end else begin
          turn_cnt_d = turn_cnt_q - TURN_ONE;
        end
      end

      RX: begin
        if (rx_busy_q) begin
          // Shift right so the first data bit ends up in bit 0.
          rx_shift_d        = rx_shift_q >> 1;
          rx_shift_d[W-1]   = I_DAT;
          if (rx_cnt_q == RX_LAST) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            rx_busy_d  = 1'b0;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + BIT_ONE;
          end
        end else if (I_DAT) begin
          rx_busy_d  = 1'b1;
          rx_cnt_d   = '0;
          rx_shift_d = '0;
        end else if (DIR_REQ) begin
          state_d    = TURN_TX;
          turn_cnt_d = TURN_INIT;
          i_en_d     = 1'b1;
        end
      end

      TURN_TX: begin
        if (turn_cnt_q == TURN_ONE) begin
          state_d    = TX;
          o_en_d     = 1'b0;
          o_dat_d    = 1'b0;
          tx_ready_d = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt_q - TURN_ONE;
        end
      end

      TX: begin
        if (tx_busy_q) begin
          // tx_cnt counts data bits already put on the pad; once all W are
          // out, one idle '0' cycle is emitted with TX_READY back high.
          if (tx_cnt_q == TX_DONE) begin
            o_dat_d    = 1'b0;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
            tx_cnt_d   = '0;
          end else begin
            o_dat_d    = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_cnt_d   = tx_cnt_q + BIT_ONE;
          end
        end else if (tx_hs) begin
          o_dat_d    = 1'b1;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
          tx_shift_d = TX_DATA;
          tx_cnt_d   = '0;
        end else if (!DIR_REQ) begin
          state_d    = TURN_RX;
          turn_cnt_d = TURN_INIT;
          o_en_d     = 1'b1;
          o_dat_d    = 1'b0;
          tx_ready_d = 1'b0;
        end
      end

      default: begin
        state_d    = TURN_RX;
        turn_cnt_d = TURN_INIT;
        o_en_d     = 1'b1;
        i_en_d     = 1'b1;
        o_dat_d    = 1'b0;
        tx_ready_d = 1'b0;
      end
    endcase
  end

  // State register. Reset lands in TURN_RX with both pad directions off and
  // throws away any partially shifted word in either direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= TURN_RX;
      turn_cnt_q <= TURN_INIT;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_ready_q <= 1'b0;
      o_dat_q    <= 1'b0;
      o_en_q     <= 1'b1;
      i_en_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_ready_q <= tx_ready_d;
      o_dat_q    <= o_dat_d;
      o_en_q     <= o_en_d;
      i_en_q     <= i_en_d;
    end
  end

  assign TX_READY = tx_ready_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign O_DAT    = o_dat_q;
  assign O_EN     = o_en_q;
  assign I_EN     = i_en_q;

endmodule

// File: tb/tb_sdiomux_hdx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdiomux_hdx_ctrl
//   Directed bench for sdiomux_hdx_ctrl with W=8, TA=2. Inputs are driven and
//   outputs observed on the falling edge. Received words and transmitted pad
//   bits are expected through scoreboard queues filled as stimulus is driven.
// ---------------------------------------------------------------------------
module tb_sdiomux_hdx_ctrl;

  logic       clk;
  logic       rst;
  logic       dirReq;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       oDat;
  logic       oEn;
  logic       iDat;
  logic       iEn;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] rxQ[$];
  logic       txQ[$];

  sdiomux_hdx_ctrl #(.W(8), .TA(2)) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIR_REQ  (dirReq),
    .TX_DATA  (txData),
    .TX_VALID (txValid),
    .TX_READY (txReady),
    .RX_DATA  (rxData),
    .RX_VALID (rxValid),
    .O_DAT    (oDat),
    .O_EN     (oEn),
    .I_DAT    (iDat),
    .I_EN     (iEn)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic d, input logic v,
                               input logic [7:0] data, input logic i);
    rst     = r;
    dirReq  = d;
    txValid = v;
    txData  = data;
    iDat    = i;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive start bit plus 8 data bits LSB first; dirAt >= 0 raises DIR_REQ
  // partway through. Returns on the falling edge where RX_VALID is due.
  task automatic sendRxWord(input logic [7:0] word, input int dirAt);
    rxQ.push_back(word);
    for (int i = 0; i < 9; i++) begin
      checkOutput("rx_i_en_low", 32'(iEn), 32'h0);
      if (i == dirAt) dirReq = 1'b1;
      iDat = (i == 0) ? 1'b1 : word[i-1];
      tick();
    end
  endtask

  // Handshake one word on the current falling edge and follow it to the
  // idle cycle after the frame. hold keeps TX_VALID high afterwards; toggle
  // flips DIR_REQ twice in mid-frame.
  task automatic sendTxWord(input logic [7:0] word, input bit hold, input bit toggle);
    checkOutput("tx_ready_before", 32'(txReady), 32'h1);
    txValid = 1'b1;
    txData  = word;
    txQ.push_back(1'b1);
    for (int i = 0; i < 8; i++) txQ.push_back(word[i]);
    txQ.push_back(1'b0);
    tick();
    txData = ~word;
    if (!hold) txValid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (toggle && (i == 2 || i == 5)) dirReq = ~dirReq;
      checkOutput("tx_bit", 32'(oDat), 32'(txQ.pop_front()));
      checkOutput("tx_ready_busy", 32'(txReady), 32'h0);
      checkOutput("tx_o_en_busy", 32'(oEn), 32'h0);
      tick();
    end
    checkOutput("tx_idle_bit", 32'(oDat), 32'(txQ.pop_front()));
    checkOutput("tx_ready_after", 32'(txReady), 32'h1);
    checkOutput("tx_o_en_after", 32'(oEn), 32'h0);
  endtask

  task automatic checkEnables(input string tag, input logic expOEn,
                              input logic expIEn, input logic expReady);
    checkOutput({tag, "_o_en"}, 32'(oEn), 32'(expOEn));
    checkOutput({tag, "_i_en"}, 32'(iEn), 32'(expIEn));
    checkOutput({tag, "_tx_ready"}, 32'(txReady), 32'(expReady));
  endtask

  // RX scoreboard and pad-enable invariants, observed every falling edge.
  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      if (rxQ.size() == 0) checkOutput("rx_unexpected_valid", 32'(rxValid), 32'h0);
      else checkOutput("rx_data_sb", 32'(rxData), 32'(rxQ.pop_front()));
    end
    checkOutput("en_exclusive", 32'(oEn | iEn), 32'h1);
    if (oEn === 1'b1) checkOutput("o_dat_when_off", 32'(oDat), 32'h0);
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    // Reset state, then a two-cycle turnaround into RX.
    checkEnables("reset", 1'b1, 1'b1, 1'b0);
    checkOutput("reset_rx_valid", 32'(rxValid), 32'h0);
    checkOutput("reset_rx_data", 32'(rxData), 32'h0);
    checkOutput("reset_o_dat", 32'(oDat), 32'h0);
    rst = 1'b0;
    tick();
    checkEnables("turn_rx_2", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("rx_entry", 1'b1, 1'b0, 1'b0);
    checkOutput("rx_entry_valid", 32'(rxValid), 32'h0);

    // Receive 0xA5 with a stray TX_VALID that must be ignored.
    txValid = 1'b1;
    txData  = 8'h77;
    sendRxWord(8'hA5, -1);
    iDat = 1'b0;
    checkOutput("rx_a5_valid", 32'(rxValid), 32'h1);
    checkOutput("rx_a5_data", 32'(rxData), 32'hA5);
    checkEnables("rx_a5", 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rx_a5_pulse_end", 32'(rxValid), 32'h0);
    checkOutput("rx_a5_hold", 32'(rxData), 32'hA5);

    // Back-to-back receive: second start bit on the edge right after a frame.
    sendRxWord(8'h5A, -1);
    sendRxWord(8'h81, -1);
    iDat = 1'b0;
    checkOutput("rx_81_data", 32'(rxData), 32'h81);
    txValid = 1'b0;
    tick();

    // Switch to TX and send 0x3C.
    dirReq = 1'b1;
    tick();
    checkEnables("turn_tx_1", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("turn_tx_2", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("tx_entry", 1'b0, 1'b1, 1'b1);
    checkOutput("tx_entry_o_dat", 32'(oDat), 32'h0);
    sendTxWord(8'h3C, 1'b0, 1'b0);

    // Back-to-back TX with TX_VALID held high.
    sendTxWord(8'hFF, 1'b1, 1'b0);
    sendTxWord(8'h01, 1'b0, 1'b0);

    // DIR_REQ=0 on the handshake edge loses; it also toggles mid-frame.
    dirReq = 1'b0;
    sendTxWord(8'h96, 1'b0, 1'b1);
    tick();
    checkEnables("turn_rx_a", 1'b1, 1'b1, 1'b0);
    checkOutput("turn_rx_a_o_dat", 32'(oDat), 32'h0);
    tick();
    checkEnables("turn_rx_b", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("rx_again", 1'b1, 1'b0, 1'b0);

    // DIR_REQ raised mid-frame in RX: frame completes, then turnaround.
    sendRxWord(8'hC3, 4);
    iDat = 1'b0;
    checkOutput("rx_c3_valid", 32'(rxValid), 32'h1);
    checkEnables("rx_c3_still_rx", 1'b1, 1'b0, 1'b0);
    tick();
    checkEnables("turn_tx_after_rx", 1'b1, 1'b1, 1'b0);
    checkOutput("rx_c3_hold", 32'(rxData), 32'hC3);
    tick();
    checkEnables("turn_tx_after_rx_2", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("tx_after_rx", 1'b0, 1'b1, 1'b1);

    // Back to RX, then reset after data bit 3 of a partial frame.
    dirReq = 1'b0;
    tick();
    tick();
    tick();
    checkEnables("rx_before_reset", 1'b1, 1'b0, 1'b0);
    iDat = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    checkEnables("mid_reset", 1'b1, 1'b1, 1'b0);
    checkOutput("mid_reset_rx_data", 32'(rxData), 32'h0);
    checkOutput("mid_reset_rx_valid", 32'(rxValid), 32'h0);
    checkOutput("mid_reset_o_dat", 32'(oDat), 32'h0);
    rst  = 1'b0;
    iDat = 1'b0;
    tick();
    checkEnables("post_reset_turn", 1'b1, 1'b1, 1'b0);
    tick();
    checkEnables("post_reset_rx", 1'b1, 1'b0, 1'b0);
    sendRxWord(8'h3C, -1);
    iDat = 1'b0;
    checkOutput("rx_3c_data", 32'(rxData), 32'h3C);
    tick();
    tick();

    checkOutput("rx_sb_drained", 32'(rxQ.size()), 32'h0);
    checkOutput("tx_sb_drained", 32'(txQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
